prog_run_supervisor: RTL and testbench
======================================

Name: prog_run_supervisor

Overview:
Synthesizable, parametrised successor to the single-program bench harness. It drives the processor's reset and start PC and runs a program until the PC reaches an end address. It then waits a settle window, compares the data-memory output against an expected value and keeps pass/run statistics. A watchdog aborts runaway programs. It sits between a host/sequencer and the singlecycle core, and lets a back-to-back list of programs be run in simulation or on FPGA.

Parameters:
ADDR_W, 64, width of PC, start and end addresses
DATA_W, 64, width of dmem_out and expected value
WDOG_W, 16, width of the watchdog/cycle counter
WDOG_LIMIT, 255, RUN cycles allowed before timeout (1..2^WDOG_W-1)
RESET_CYCLES, 1, cycles cpu_resetl is held low per run (>=1)
SETTLE_CYCLES, 1, cycles after end PC is reached before sampling dmem_out (>=0)
CNT_W, 8, width of pass_count and run_count

Ports:
CLK  in  1  clock, rising edge
resetl  in  1  asynchronous active-low reset
start  in  1  run request; accepted only in IDLE
start_pc_in  in  ADDR_W  program start PC; latched on accept
end_pc_in  in  ADDR_W  terminating PC; latched on accept
expected_in  in  DATA_W  expected dmem_out; latched on accept
clear_counts  in  1  synchronous clear of pass_count/run_count
current_pc  in  ADDR_W  from core currentpc
dmem_out  in  DATA_W  from core dmemout
cpu_resetl  out  1  to core resetl
cpu_startpc  out  ADDR_W  to core startpc (latched start PC)
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when a run finishes
pass  out  1  result of last run; held until next accept
timeout  out  1  last run hit the watchdog; held until next accept
cycle_count  out  WDOG_W  RUN cycles of the current/last run
pass_count  out  CNT_W  saturating count of passed runs
run_count  out  CNT_W  saturating count of completed runs

Behaviour:
- Reset (async, resetl=0): state IDLE. cpu_resetl=0, cpu_startpc=0, busy=0, done=0, pass=0, timeout=0, cycle_count=0, pass_count=0, run_count=0. Latched registers are cleared.
- All outputs are registered. cpu_resetl=1 only in RUN, SETTLE and CHECK; it is 0 otherwise.
- IDLE: start=1 at an edge latches the three inputs. The same edge clears pass, timeout and cycle_count, loads the phase counter to RESET_CYCLES-1 and moves to RESET. A start outside IDLE is ignored and not queued.
- RESET: holds the core in reset for exactly RESET_CYCLES cycles, then moves to RUN.
- RUN: cycle_count increments each cycle.
  - If current_pc >= end_pc (unsigned), the next state is SETTLE, or CHECK when SETTLE_CYCLES=0. The end check takes priority over the watchdog on the same edge.
  - Otherwise, if cycle_count == WDOG_LIMIT-1: timeout=1, pass=0, done=1, run_count increments, and the next state is IDLE.
- SETTLE: waits SETTLE_CYCLES cycles, then moves to CHECK.
- CHECK: single cycle. pass <= (dmem_out == expected), run_count increments, pass_count increments if pass, done=1, and the next state is IDLE.
- done is high for exactly one cycle: the first IDLE cycle after completion.
- Counters saturate at 2^CNT_W-1. cycle_count saturates at WDOG_LIMIT.
- clear_counts takes effect in any state. When it coincides with a completion increment, the clear wins and both counts become 0.
- A start in the cycle done is high is accepted normally, giving back-to-back runs.
- Reset mid-run returns to IDLE immediately with cpu_resetl=0. No done pulse is produced.
- Run latency with no timeout: RESET_CYCLES + N_run + SETTLE_CYCLES + 1 cycles from accept to done. N_run counts RUN cycles up to and including the one where the end condition is seen.

Decomposition:
- Package sup_pkg holds the state enum (IDLE, RESET, RUN, SETTLE, CHECK) and localparams for the counter widths derived from RESET_CYCLES/SETTLE_CYCLES.
- One natural sub-module, sat_counter (parametrised width, inc, clr, clr-priority), instantiated for pass_count, run_count and cycle_count.

Test Plan:
- Stub core: PC advances 4/cycle from 0; end_pc=0x34, expected=0xF, dmem_out=0xF after PC>=0x34. Start → required: done after 1+14+1+1 cycles, pass=1, pass_count=1, run_count=1, cycle_count=14.
- Same run with dmem_out=0xE → pass=0, timeout=0, run_count=1, pass_count=0.
- PC frozen at 0x10, end_pc=0x34, WDOG_LIMIT=255 → timeout=1, pass=0, cycle_count=255, done exactly 1+255 cycles after accept.
- start asserted while busy in RUN → ignored. Start re-asserted in the done cycle → second run begins, run_count reaches 2.
- resetl pulsed low mid-RUN → cpu_resetl=0 and busy=0 immediately, no done, counters=0.
- CNT_W=2: four passing runs → pass_count saturates at 3. clear_counts asserted together with the 4th completion → both counts 0.

Source files
------------

// File: rtl/prog_run_supervisor_pkg.sv
// Shared types and helpers for the program-run supervisor.
package sup_pkg;

  // Supervisor sequencing states.
  typedef enum logic [2:0] {
    IDLE,
    RESET,
    RUN,
    SETTLE,
    CHECK
  } state_t;

  // Narrowest phase counter ever built, even when both windows are one cycle.
  localparam int unsigned PHASE_W_MIN = 1;

  // Bits needed to hold a down-counter loaded with n-1.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? PHASE_W_MIN : $clog2(n);
  endfunction

  // Larger of two cycle counts, used to size the shared phase counter.
  function automatic int unsigned max_cycles(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/prog_run_supervisor_sat_counter.sv
// Saturating up-counter with a synchronous clear that beats increment.
module sat_counter #(
  parameter int unsigned    W   = 8,
  parameter logic [W-1:0]   MAX = '1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Clear has priority; increment stops at MAX.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (inc && (count != MAX)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/prog_run_supervisor.sv
// Runs one program on the core: reset, run to end PC, settle, check result.
module prog_run_supervisor
  import sup_pkg::*;
#(
  parameter int unsigned ADDR_W        = 64,
  parameter int unsigned DATA_W        = 64,
  parameter int unsigned WDOG_W        = 16,
  parameter int unsigned WDOG_LIMIT    = 255,
  parameter int unsigned RESET_CYCLES  = 1,
  parameter int unsigned SETTLE_CYCLES = 1,
  parameter int unsigned CNT_W         = 8
) (
  input  logic              CLK,
  input  logic              resetl,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_pc_in,
  input  logic [ADDR_W-1:0] end_pc_in,
  input  logic [DATA_W-1:0] expected_in,
  input  logic              clear_counts,
  input  logic [ADDR_W-1:0] current_pc,
  input  logic [DATA_W-1:0] dmem_out,
  output logic              cpu_resetl,
  output logic [ADDR_W-1:0] cpu_startpc,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic              timeout,
  output logic [WDOG_W-1:0] cycle_count,
  output logic [CNT_W-1:0]  pass_count,
  output logic [CNT_W-1:0]  run_count
);

  localparam int unsigned PHASE_W     = cnt_width(max_cycles(RESET_CYCLES, SETTLE_CYCLES));
  localparam int unsigned SETTLE_LOAD = (SETTLE_CYCLES > 0) ? SETTLE_CYCLES - 1 : 0;

  state_t              state, state_nxt;
  logic [PHASE_W-1:0]  phase, phase_nxt;
  logic [ADDR_W-1:0]   end_pc_q;
  logic [DATA_W-1:0]   expected_q;
  logic                accept, wdog_fire, check_done, data_match;

  assign accept     = (state == IDLE) && start;
  assign data_match = (dmem_out == expected_q);

  // Next-state and phase-counter decode; end-PC check outranks the watchdog.
  always_comb begin
    state_nxt  = state;
    phase_nxt  = phase;
    wdog_fire  = 1'b0;
    check_done = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          state_nxt = RESET;
          phase_nxt = PHASE_W'(RESET_CYCLES - 1);
        end
      end
      RESET: begin
        if (phase == '0) state_nxt = RUN;
        else             phase_nxt = phase - PHASE_W'(1);
      end
      RUN: begin
        if (current_pc >= end_pc_q) begin
          if (SETTLE_CYCLES == 0) begin
            state_nxt = CHECK;
          end else begin
            state_nxt = SETTLE;
            phase_nxt = PHASE_W'(SETTLE_LOAD);
          end
        end else if (cycle_count == WDOG_W'(WDOG_LIMIT - 1)) begin
          wdog_fire = 1'b1;
          state_nxt = IDLE;
        end
      end
      SETTLE: begin
        if (phase == '0) state_nxt = CHECK;
        else             phase_nxt = phase - PHASE_W'(1);
      end
      CHECK: begin
        check_done = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, latched run parameters and registered status outputs.
  always_ff @(posedge CLK or negedge resetl) begin
    if (!resetl) begin
      state       <= IDLE;
      phase       <= '0;
      cpu_startpc <= '0;
      end_pc_q    <= '0;
      expected_q  <= '0;
      cpu_resetl  <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      pass        <= 1'b0;
      timeout     <= 1'b0;
    end else begin
      state      <= state_nxt;
      phase      <= phase_nxt;
      // Outputs are decoded from the next state so they line up with the state register.
      cpu_resetl <= (state_nxt == RUN) || (state_nxt == SETTLE) || (state_nxt == CHECK);
      busy       <= (state_nxt != IDLE);
      done       <= wdog_fire || check_done;
      if (accept) begin
        cpu_startpc <= start_pc_in;
        end_pc_q    <= end_pc_in;
        expected_q  <= expected_in;
        pass        <= 1'b0;
        timeout     <= 1'b0;
      end else if (wdog_fire) begin
        pass    <= 1'b0;
        timeout <= 1'b1;
      end else if (check_done) begin
        pass <= data_match;
      end
    end
  end

  sat_counter #(.W(WDOG_W), .MAX(WDOG_W'(WDOG_LIMIT))) u_cycle_cnt (
    .clk   (CLK),
    .rst_n (resetl),
    .clr   (accept),
    .inc   (state == RUN),
    .count (cycle_count)
  );

  sat_counter #(.W(CNT_W)) u_run_cnt (
    .clk   (CLK),
    .rst_n (resetl),
    .clr   (clear_counts),
    .inc   (wdog_fire || check_done),
    .count (run_count)
  );

  sat_counter #(.W(CNT_W)) u_pass_cnt (
    .clk   (CLK),
    .rst_n (resetl),
    .clr   (clear_counts),
    .inc   (check_done && data_match),
    .count (pass_count)
  );

endmodule

// File: tb/tb_prog_run_supervisor.sv
// Directed bench for prog_run_supervisor with a stub core (PC += 4 per cycle).
module tb_prog_run_supervisor;

  logic        CLK = 1'b0;
  logic        resetl;
  logic        start;
  logic [63:0] start_pc_in, end_pc_in, expected_in;
  logic        clear_counts;
  logic [63:0] current_pc, dmem_out;
  logic        cpu_resetl;
  logic [63:0] cpu_startpc;
  logic        busy, done, pass, timeout;
  logic [15:0] cycle_count;
  logic [1:0]  pass_count, run_count;

  int checks = 0;
  int passed = 0;

  // Stub core state
  logic [63:0] pc_run;
  logic        freeze;
  logic [63:0] dmem_val;

  always #5 CLK = ~CLK;

  prog_run_supervisor #(
    .ADDR_W(64), .DATA_W(64), .WDOG_W(16), .WDOG_LIMIT(255),
    .RESET_CYCLES(1), .SETTLE_CYCLES(1), .CNT_W(2)
  ) dut (
    .CLK(CLK), .resetl(resetl), .start(start), .start_pc_in(start_pc_in),
    .end_pc_in(end_pc_in), .expected_in(expected_in), .clear_counts(clear_counts),
    .current_pc(current_pc), .dmem_out(dmem_out), .cpu_resetl(cpu_resetl),
    .cpu_startpc(cpu_startpc), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .cycle_count(cycle_count), .pass_count(pass_count),
    .run_count(run_count)
  );

  // Stub core: PC held at 0 in reset, advances by 4 per cycle otherwise.
  always_ff @(posedge CLK) begin
    if (!cpu_resetl) pc_run <= '0;
    else             pc_run <= pc_run + 64'd4;
  end

  assign current_pc = freeze ? 64'h10 : pc_run;
  assign dmem_out   = (current_pc >= 64'h34) ? dmem_val : 64'h0;

  task automatic apply_reset();
    resetl = 1'b0; start = 1'b0; clear_counts = 1'b0;
    start_pc_in = '0; end_pc_in = '0; expected_in = '0;
    freeze = 1'b0; dmem_val = 64'hF;
    repeat (2) @(posedge CLK);
    #1 resetl = 1'b1;
  endtask

  // Issues a start (caller is IDLE, #1 after an edge) and returns edges from accept to done.
  task automatic do_run(input logic [63:0] epc, input logic [63:0] exp_v, output int lat);
    start = 1'b1; start_pc_in = 64'h40; end_pc_in = epc; expected_in = exp_v;
    @(posedge CLK); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge CLK); #1;
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic test_reset();
    resetl = 1'b0; start = 1'b0; clear_counts = 1'b0; freeze = 1'b0; dmem_val = 64'hF;
    start_pc_in = '0; end_pc_in = '0; expected_in = '0;
    repeat (2) @(posedge CLK);
    #1;
    checks++; if (cpu_resetl !== 1'b0) $display("FAIL reset_cpu_resetl got %b want 0", cpu_resetl); else passed++;
    checks++; if (cpu_startpc !== 64'h0) $display("FAIL reset_startpc got %h want 0", cpu_startpc); else passed++;
    checks++; if ({busy, done, pass, timeout} !== 4'b0) $display("FAIL reset_flags got %b want 0000", {busy, done, pass, timeout}); else passed++;
    checks++; if (cycle_count !== 16'd0) $display("FAIL reset_cycle_count got %0d want 0", cycle_count); else passed++;
    checks++; if ({pass_count, run_count} !== 4'b0) $display("FAIL reset_counts got %0d/%0d want 0/0", pass_count, run_count); else passed++;
    resetl = 1'b1;
  endtask

  task automatic test_pass_run();
    int lat;
    apply_reset();
    @(posedge CLK); #1;
    do_run(64'h34, 64'hF, lat);
    checks++; if (lat !== 17) $display("FAIL pass_latency got %0d want 17", lat); else passed++;
    checks++; if (pass !== 1'b1 || timeout !== 1'b0) $display("FAIL pass_result got pass=%b to=%b want 1 0", pass, timeout); else passed++;
    checks++; if (cycle_count !== 16'd14) $display("FAIL pass_cycle_count got %0d want 14", cycle_count); else passed++;
    checks++; if (pass_count !== 2'd1 || run_count !== 2'd1) $display("FAIL pass_counts got %0d/%0d want 1/1", pass_count, run_count); else passed++;
    checks++; if (cpu_startpc !== 64'h40) $display("FAIL pass_startpc got %h want 40", cpu_startpc); else passed++;
    @(posedge CLK); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0 || cpu_resetl !== 1'b0) $display("FAIL pass_after_done got done=%b busy=%b cr=%b want 0 0 0", done, busy, cpu_resetl); else passed++;
  endtask

  task automatic test_fail_run();
    int lat;
    apply_reset();
    dmem_val = 64'hE;
    @(posedge CLK); #1;
    do_run(64'h34, 64'hF, lat);
    checks++; if (lat !== 17) $display("FAIL fail_latency got %0d want 17", lat); else passed++;
    checks++; if (pass !== 1'b0 || timeout !== 1'b0) $display("FAIL fail_result got pass=%b to=%b want 0 0", pass, timeout); else passed++;
    checks++; if (pass_count !== 2'd0 || run_count !== 2'd1) $display("FAIL fail_counts got %0d/%0d want 0/1", pass_count, run_count); else passed++;
  endtask

  task automatic test_timeout();
    int lat;
    apply_reset();
    freeze = 1'b1;
    @(posedge CLK); #1;
    do_run(64'h34, 64'hF, lat);
    checks++; if (lat !== 256) $display("FAIL to_latency got %0d want 256", lat); else passed++;
    checks++; if (timeout !== 1'b1 || pass !== 1'b0) $display("FAIL to_result got to=%b pass=%b want 1 0", timeout, pass); else passed++;
    checks++; if (cycle_count !== 16'd255) $display("FAIL to_cycle_count got %0d want 255", cycle_count); else passed++;
    checks++; if (run_count !== 2'd1 || pass_count !== 2'd0) $display("FAIL to_counts got %0d/%0d want 0/1", pass_count, run_count); else passed++;
    freeze = 1'b0;
  endtask

  task automatic test_back_to_back();
    int lat;
    apply_reset();
    @(posedge CLK); #1;
    start = 1'b1; start_pc_in = 64'h40; end_pc_in = 64'h34; expected_in = 64'hF;
    @(posedge CLK); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 400; i++) begin
      @(posedge CLK); #1;
      start = (i == 5);
      end_pc_in = (i == 5) ? 64'h8 : 64'h34;
      if (done) begin lat = i; break; end
    end
    start = 1'b0;
    checks++; if (lat !== 17) $display("FAIL busy_start_latency got %0d want 17", lat); else passed++;
    checks++; if (cycle_count !== 16'd14 || pass !== 1'b1) $display("FAIL busy_start_result got cc=%0d pass=%b want 14 1", cycle_count, pass); else passed++;
    // start raised in the done cycle
    do_run(64'h34, 64'hF, lat);
    checks++; if (lat !== 17) $display("FAIL b2b_latency got %0d want 17", lat); else passed++;
    checks++; if (run_count !== 2'd2 || pass_count !== 2'd2) $display("FAIL b2b_counts got %0d/%0d want 2/2", pass_count, run_count); else passed++;
  endtask

  task automatic test_reset_midrun();
    int lat;
    int done_seen;
    apply_reset();
    @(posedge CLK); #1;
    do_run(64'h34, 64'hF, lat);
    start = 1'b1; end_pc_in = 64'h34;
    @(posedge CLK); #1;
    start = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    checks++; if (busy !== 1'b1 || cpu_resetl !== 1'b1) $display("FAIL midrun_pre got busy=%b cr=%b want 1 1", busy, cpu_resetl); else passed++;
    resetl = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || cpu_resetl !== 1'b0) $display("FAIL midrun_async got busy=%b cr=%b want 0 0", busy, cpu_resetl); else passed++;
    checks++; if (run_count !== 2'd0 || pass_count !== 2'd0 || cycle_count !== 16'd0) $display("FAIL midrun_counts got %0d/%0d cc=%0d want 0/0 0", pass_count, run_count, cycle_count); else passed++;
    resetl = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge CLK); #1;
      if (done) done_seen++;
    end
    checks++; if (done_seen !== 0) $display("FAIL midrun_no_done got %0d pulses want 0", done_seen); else passed++;
  endtask

  task automatic test_saturate_clear();
    int lat;
    apply_reset();
    @(posedge CLK); #1;
    for (int r = 0; r < 4; r++) do_run(64'h34, 64'hF, lat);
    checks++; if (pass_count !== 2'd3 || run_count !== 2'd3) $display("FAIL sat_counts got %0d/%0d want 3/3", pass_count, run_count); else passed++;
    clear_counts = 1'b1;
    @(posedge CLK); #1;
    clear_counts = 1'b0;
    checks++; if (pass_count !== 2'd0 || run_count !== 2'd0) $display("FAIL clear_idle got %0d/%0d want 0/0", pass_count, run_count); else passed++;
    for (int r = 0; r < 3; r++) do_run(64'h34, 64'hF, lat);
    checks++; if (pass_count !== 2'd3 || run_count !== 2'd3) $display("FAIL three_runs got %0d/%0d want 3/3", pass_count, run_count); else passed++;
    // Fourth run: clear_counts held during the CHECK cycle so it meets the completion edge.
    start = 1'b1; end_pc_in = 64'h34; expected_in = 64'hF;
    @(posedge CLK); #1;
    start = 1'b0;
    for (int i = 1; i <= 17; i++) begin
      @(posedge CLK); #1;
      clear_counts = (i == 16);
    end
    clear_counts = 1'b0;
    checks++; if (done !== 1'b1 || pass !== 1'b1) $display("FAIL clear_done got done=%b pass=%b want 1 1", done, pass); else passed++;
    checks++; if (pass_count !== 2'd0 || run_count !== 2'd0) $display("FAIL clear_wins got %0d/%0d want 0/0", pass_count, run_count); else passed++;
  endtask

  initial begin
    test_reset();
    test_pass_run();
    test_fail_run();
    test_timeout();
    test_back_to_back();
    test_reset_midrun();
    test_saturate_clear();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
